// File: rtl/led_blink_multi.sv
// rtl/led_blink_multi.sv - multi-channel programmable timebase / LED driver
// Each channel runs its own period counter and drives led_out/tick/busy per its mode.
module led_blink_multi #(
   parameter int  CNT_W       = 25,
   parameter int  CH          = 4,
   parameter int  CNT_MAX_DEF = 24_999_999,
   localparam int CH_W        = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [1:0]       cfg_mode,
   input  logic             cfg_en,
   output logic [CH-1:0]    led_out,
   output logic [CH-1:0]    tick,
   output logic [CH-1:0]    busy
);

   localparam logic [CNT_W-1:0] P_DEF    = CNT_W'(CNT_MAX_DEF);
   localparam logic [1:0]       M_PULSE  = 2'b01;
   localparam logic [1:0]       M_ONESHOT = 2'b10;

   logic [CH-1:0][CNT_W-1:0] period_q, period_d;
   logic [CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [CH-1:0][1:0]       mode_q, mode_d;
   logic [CH-1:0]            en_q, en_d;
   logic [CH-1:0]            led_q, led_d;
   logic [CH-1:0]            tick_q, tick_d;
   logic [CH-1:0]            busy_q, busy_d;

   always_comb begin
      period_d = period_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      en_d     = en_q;
      led_d    = led_q;
      tick_d   = tick_q;
      busy_d   = busy_q;
      for (int c = 0; c < CH; c++) begin
         if (!en_q[c]) begin
            cnt_d[c]  = '0;
            tick_d[c] = 1'b0;
            led_d[c]  = 1'b0;
            busy_d[c] = 1'b0;
         end else if (cnt_q[c] == period_q[c]) begin
            cnt_d[c]  = '0;
            tick_d[c] = 1'b1;
            case (mode_q[c])
               M_PULSE:   led_d[c] = 1'b1;
               M_ONESHOT: begin
                  led_d[c]  = 1'b0;
                  busy_d[c] = 1'b0;
                  en_d[c]   = 1'b0;
               end
               default:   led_d[c] = ~led_q[c];
            endcase
         end else begin
            cnt_d[c]  = cnt_q[c] + CNT_W'(1);
            tick_d[c] = 1'b0;
            if (mode_q[c] == M_PULSE) begin
               led_d[c] = 1'b0;
            end
         end
         // A config write restarts the channel and wins over a same-edge wrap.
         if (cfg_we && (cfg_ch == CH_W'(c))) begin
            period_d[c] = cfg_period;
            mode_d[c]   = cfg_mode;
            en_d[c]     = cfg_en;
            cnt_d[c]    = '0;
            tick_d[c]   = 1'b0;
            led_d[c]    = (cfg_mode == M_ONESHOT) && cfg_en;
            busy_d[c]   = (cfg_mode == M_ONESHOT) && cfg_en;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         period_q <= {CH{P_DEF}};
         cnt_q    <= '0;
         mode_q   <= '0;
         en_q     <= '1;
         led_q    <= '0;
         tick_q   <= '0;
         busy_q   <= '0;
      end else begin
         period_q <= period_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         en_q     <= en_d;
         led_q    <= led_d;
         tick_q   <= tick_d;
         busy_q   <= busy_d;
      end
   end

   assign led_out = led_q;
   assign tick    = tick_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_led_blink_multi.sv
// tb/tb_led_blink_multi.sv - scoreboard bench for led_blink_multi (CH=2 and CH=3 builds)
// Expected outputs are predicted from cycles elapsed since each channel's last restart.
module tb_led_blink_multi;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       cfg_we  = 1'b0;
   logic       cfg_ch  = 1'b0;
   logic       cfg_we3 = 1'b0;
   logic [1:0] cfg_ch3 = 2'd0;
   logic [3:0] cfg_period = 4'd0;
   logic [1:0] cfg_mode   = 2'd0;
   logic       cfg_en     = 1'b0;
   logic [1:0] led0, tick0, busy0;
   logic [2:0] led1, tick1, busy1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [5:0] sb0[$];
   logic [8:0] sb1[$];

   // Model state, [dut][channel]
   int   m_p[2][3];
   int   m_mode[2][3];
   int   m_k[2][3];
   logic m_en[2][3];
   logic m_led[2][3];
   logic m_tick[2][3];
   logic m_busy[2][3];

   always #5 sys_clk = ~sys_clk;

   led_blink_multi #(.CNT_W(4), .CH(2), .CNT_MAX_DEF(3)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_period(cfg_period), .cfg_mode(cfg_mode), .cfg_en(cfg_en),
      .led_out(led0), .tick(tick0), .busy(busy0)
   );

   led_blink_multi #(.CNT_W(4), .CH(3), .CNT_MAX_DEF(3)) dut3 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3),
      .cfg_period(cfg_period), .cfg_mode(cfg_mode), .cfg_en(cfg_en),
      .led_out(led1), .tick(tick1), .busy(busy1)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_edge(input int d, input int n, input logic we, input int ch);
      int per;
      for (int c = 0; c < n; c++) begin
         if (sys_rst) begin
            m_p[d][c] = 3; m_mode[d][c] = 0; m_en[d][c] = 1'b1; m_k[d][c] = 0;
            m_led[d][c] = 1'b0; m_tick[d][c] = 1'b0; m_busy[d][c] = 1'b0;
         end else if (we && ch == c) begin
            m_p[d][c] = int'(cfg_period); m_mode[d][c] = int'(cfg_mode);
            m_en[d][c] = cfg_en; m_k[d][c] = 0; m_tick[d][c] = 1'b0;
            m_led[d][c]  = (cfg_mode == 2'b10) && cfg_en;
            m_busy[d][c] = (cfg_mode == 2'b10) && cfg_en;
         end else if (!m_en[d][c]) begin
            m_k[d][c] = 0;
            m_led[d][c] = 1'b0; m_tick[d][c] = 1'b0; m_busy[d][c] = 1'b0;
         end else begin
            m_k[d][c]++;
            per = m_p[d][c] + 1;
            m_tick[d][c] = (m_k[d][c] % per) == 0;
            m_busy[d][c] = 1'b0;
            if (m_mode[d][c] == 1) begin
               m_led[d][c] = m_tick[d][c];
            end else if (m_mode[d][c] == 2) begin
               m_led[d][c]  = m_k[d][c] < per;
               m_busy[d][c] = m_k[d][c] < per;
               if (m_k[d][c] == per) m_en[d][c] = 1'b0;
            end else begin
               m_led[d][c] = ((m_k[d][c] / per) % 2) == 1;
            end
         end
      end
   endtask

   task automatic step();
      logic [5:0] e0, o0;
      logic [8:0] e1, o1;
      model_edge(0, 2, cfg_we, int'(cfg_ch));
      model_edge(1, 3, cfg_we3, int'(cfg_ch3));
      sb0.push_back({m_led[0][1], m_led[0][0], m_tick[0][1], m_tick[0][0],
                     m_busy[0][1], m_busy[0][0]});
      sb1.push_back({m_led[1][2], m_led[1][1], m_led[1][0], m_tick[1][2], m_tick[1][1],
                     m_tick[1][0], m_busy[1][2], m_busy[1][1], m_busy[1][0]});
      @(posedge sys_clk);
      #1;
      cyc++;
      o0 = {led0, tick0, busy0};
      o1 = {led1, tick1, busy1};
      e0 = sb0.pop_front();
      e1 = sb1.pop_front();
      check_eq($sformatf("dut_ch2 led/tick/busy cyc%0d", cyc), 32'(o0), 32'(e0));
      check_eq($sformatf("dut_ch3 led/tick/busy cyc%0d", cyc), 32'(o1), 32'(e1));
      cfg_we  = 1'b0;
      cfg_we3 = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input logic ch, input logic [3:0] p, input logic [1:0] m, input logic en);
      cfg_we = 1'b1; cfg_ch = ch; cfg_period = p; cfg_mode = m; cfg_en = en;
      step();
   endtask

   initial begin
      bit found;
      run(2);
      sys_rst = 1'b0;
      run(5);
      sys_rst = 1'b1;
      run(1);
      sys_rst = 1'b0;
      run(10);

      wr(1'b1, 4'd0, 2'b00, 1'b1);
      run(10);

      wr(1'b0, 4'd5, 2'b01, 1'b1);
      run(14);

      wr(1'b1, 4'd2, 2'b10, 1'b1);
      run(8);
      wr(1'b1, 4'd2, 2'b10, 1'b1);
      run(6);

      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (((m_k[0][0] + 1) % (m_p[0][0] + 1)) == 0) found = 1'b1;
         else step();
      end
      if (!found) check_eq("wrap_wait", 32'd0, 32'd1);
      wr(1'b0, 4'd3, 2'b00, 1'b1);
      run(10);

      cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_period = 4'd1; cfg_mode = 2'b01; cfg_en = 1'b0;
      step();
      run(10);

      wr(1'b0, 4'd2, 2'b00, 1'b0);
      run(10);
      wr(1'b0, 4'd2, 2'b00, 1'b1);
      run(8);

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
